// File: rtl/argus_top.sv
`timescale 1ns/1ps
// argus_top: SPI mode-0 slave bridged into a byte-wide register file.
// A transaction is one address byte followed by auto-incrementing data bytes.
// Reads use a one-byte turnaround. Data byte 0xFF acts as a read/dummy byte.
//
// Ports:
//   clk      system clock (12 MHz nominal); sclk must be <= clk/8
//   sys_rst  asynchronous active-low reset
//   sclk     SPI clock, idle low
//   mosi     SPI data in, MSB first, sampled on sclk rise
//   cs_n     SPI chip select, active low
//   miso     SPI data out, MSB first, changes on sclk fall
//   led_r/g/b  active-low LED drives from LED_CTRL[2]/[1]/[0]
//
// Register map: 0x00-0x04 "ARGUS" (RO), 0x05 ID_VERSION (RO), 0x06 0x00 (RO),
// 0x10 LED_CTRL (RW), 0x20 SCRATCH (RW, only with ARGUS_SCRATCH_REG_EN).
module argus_top #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  ID_VERSION  = 8'h01
) (
    input  logic clk,
    input  logic sys_rst,
    input  logic sclk,
    input  logic mosi,
    input  logic cs_n,
    output logic miso,
    output logic led_r,
    output logic led_g,
    output logic led_b
);

    typedef enum logic {ST_ADDR, ST_DATA} state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync;
    logic       sclk_s, mosi_s, cs_s, sclk_d;
    logic       rise, fall, active;
    logic       framed;
    logic [2:0] bitcnt;
    logic [6:0] shreg;
    logic [7:0] byte_in;
    logic [7:0] wr_ptr, rd_ptr;
    logic [7:0] out_sh;
    logic       load_pend, rd_armed;
    logic [7:0] led_ctrl;
    logic [7:0] rd_data;
`ifdef ARGUS_SCRATCH_REG_EN
    logic [7:0] scratch;
`endif

    // cs_n chain resets to "selected" so that a cs_n held low across reset
    // release is not mistaken for a new frame; framed arms only after cs_n
    // has been seen high.
    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            cs_sync   <= '0;
            sclk_d    <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            sclk_d    <= sclk_s;
        end
    end

    assign sclk_s  = sclk_sync[SYNC_STAGES-1];
    assign mosi_s  = mosi_sync[SYNC_STAGES-1];
    assign cs_s    = cs_sync[SYNC_STAGES-1];
    assign rise    = sclk_s & ~sclk_d;
    assign fall    = ~sclk_s & sclk_d;
    assign active  = framed & ~cs_s;
    assign byte_in = {shreg, mosi_s};

    always_comb begin
        rd_data = '0;
        case (rd_ptr)
            8'h00: rd_data = 8'h41;
            8'h01: rd_data = 8'h52;
            8'h02: rd_data = 8'h47;
            8'h03: rd_data = 8'h55;
            8'h04: rd_data = 8'h53;
            8'h05: rd_data = ID_VERSION;
            8'h10: rd_data = led_ctrl;
`ifdef ARGUS_SCRATCH_REG_EN
            8'h20: rd_data = scratch;
`endif
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) state <= ST_ADDR;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (!active)
            state_next = ST_ADDR;
        else if (state == ST_ADDR && rise && bitcnt == 3'd7)
            state_next = ST_DATA;
    end

    // rd_armed marks that data byte 1 has completed; until then the byte
    // loaded at each byte boundary is the 0x00 turnaround filler.
    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            framed    <= 1'b0;
            bitcnt    <= '0;
            shreg     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            out_sh    <= '0;
            load_pend <= 1'b0;
            rd_armed  <= 1'b0;
            led_ctrl  <= '0;
`ifdef ARGUS_SCRATCH_REG_EN
            scratch   <= '0;
`endif
        end else begin
            if (cs_s) framed <= 1'b1;
            if (!active) begin
                bitcnt    <= '0;
                out_sh    <= '0;
                load_pend <= 1'b0;
                rd_armed  <= 1'b0;
            end else begin
                if (rise) begin
                    shreg  <= byte_in[6:0];
                    bitcnt <= bitcnt + 3'd1;
                    if (bitcnt == 3'd7) begin
                        load_pend <= 1'b1;
                        if (state == ST_ADDR) begin
                            wr_ptr <= byte_in;
                            rd_ptr <= byte_in;
                        end else begin
                            rd_armed <= 1'b1;
                            wr_ptr   <= wr_ptr + 8'd1;
                            if (byte_in != 8'hFF) begin
                                if (wr_ptr == 8'h10) led_ctrl <= byte_in;
`ifdef ARGUS_SCRATCH_REG_EN
                                if (wr_ptr == 8'h20) scratch <= byte_in;
`endif
                            end
                        end
                    end
                end
                if (fall) begin
                    if (load_pend) begin
                        load_pend <= 1'b0;
                        if (rd_armed) begin
                            out_sh <= rd_data;
                            rd_ptr <= rd_ptr + 8'd1;
                        end else begin
                            out_sh <= '0;
                        end
                    end else begin
                        out_sh <= {out_sh[6:0], 1'b0};
                    end
                end
            end
        end
    end

    assign miso  = out_sh[7];
    assign led_b = ~led_ctrl[0];
    assign led_g = ~led_ctrl[1];
    assign led_r = ~led_ctrl[2];

endmodule

// File: tb/tb_argus_top.sv
`timescale 1ns/1ps
module tb_argus_top;

    logic clk, sys_rst, sclk, mosi, cs_n;
    logic miso, led_r, led_g, led_b;

    int unsigned checks = 0;
    int unsigned passes = 0;

    argus_top #(.SYNC_STAGES(2), .ID_VERSION(8'h01)) dut (
        .clk    (clk),
        .sys_rst(sys_rst),
        .sclk   (sclk),
        .mosi   (mosi),
        .cs_n   (cs_n),
        .miso   (miso),
        .led_r  (led_r),
        .led_g  (led_g),
        .led_b  (led_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic leds(input string tag, input logic [2:0] exp_rgb);
        check(tag, {5'd0, led_r, led_g, led_b}, {5'd0, exp_rgb});
    endtask

    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            mosi = tx[i];
            #80; sclk = 1'b1; rx[i] = miso;
            #80; sclk = 1'b0;
        end
    endtask

    task automatic partial(input logic [7:0] tx, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            mosi = tx[i];
            #80; sclk = 1'b1;
            #80; sclk = 1'b0;
        end
    endtask

    task automatic cs_begin();
        cs_n = 1'b0; #160;
    endtask

    task automatic cs_end();
        #160; cs_n = 1'b1; #160;
    endtask

    task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
        logic [7:0] r;
        cs_begin(); xfer(a, r); xfer(d, r); cs_end();
    endtask

    task automatic rd_reg(input logic [7:0] a, output logic [7:0] v);
        logic [7:0] r;
        cs_begin(); xfer(a, r); xfer(8'hFF, r); xfer(8'hFF, v); cs_end();
    endtask

    logic [7:0] r, r1, r2, r3;
    logic [7:0] exp_id [8];

    initial begin
        exp_id = '{8'h00, 8'h00, 8'h41, 8'h52, 8'h47, 8'h55, 8'h53, 8'h01};
        sys_rst = 1'b0; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
        #100;
        leds("reset_leds", 3'b111);
        check("reset_miso", {7'd0, miso}, 8'h00);
        sys_rst = 1'b1; #100;

        // ID string dump: data bytes 1..7
        cs_begin();
        xfer(8'h00, r);
        for (int k = 1; k <= 7; k++) begin
            xfer(8'hFF, r);
            check($sformatf("id_byte%0d", k), r, exp_id[k]);
        end
        cs_end();
        leds("id_leds", 3'b111);

        // LED write, blue on
        wr_reg(8'h10, 8'h01);
        leds("led_blue", 3'b110);
        rd_reg(8'h10, r);
        check("led_rd_01", r, 8'h01);
        leds("led_after_rd", 3'b110);

        // green + red on, then reset
        wr_reg(8'h10, 8'h06);
        leds("led_gr", 3'b001);
        sys_rst = 1'b0; #50;
        leds("rst_leds", 3'b111);
        check("rst_miso", {7'd0, miso}, 8'h00);
        sys_rst = 1'b1; #100;
        rd_reg(8'h10, r);
        check("rst_ledctrl", r, 8'h00);

        // aborted data byte must not write
        cs_begin(); xfer(8'h10, r); partial(8'h07, 4);
        cs_n = 1'b1; #160;
        leds("abort_nowrite", 3'b111);
        wr_reg(8'h10, 8'h02);
        leds("after_abort", 3'b101);

        // reset mid-transaction with cs_n held low: bytes ignored until new frame
        cs_begin(); xfer(8'h10, r); partial(8'h05, 4);
        sys_rst = 1'b0; #50; sys_rst = 1'b1; #100;
        xfer(8'h10, r); xfer(8'h05, r);
        cs_end();
        leds("midrst_nowrite", 3'b111);
        rd_reg(8'h10, r);
        check("midrst_ledctrl", r, 8'h00);

        // write then read back in the same transaction
        cs_begin(); xfer(8'h10, r); xfer(8'hFB, r1); xfer(8'hFF, r2); cs_end();
        check("same_txn_b1", r1, 8'h00);
        check("same_txn_rd", r2, 8'hFB);
        leds("led_fb", 3'b100);

        // writes to RO / unmapped addresses ignored
        wr_reg(8'h00, 8'h12);
        rd_reg(8'h00, r);
        check("ro_write_ign", r, 8'h41);
        rd_reg(8'h06, r);
        check("rd_06", r, 8'h00);
        wr_reg(8'h11, 8'h33);
        rd_reg(8'h11, r);
        check("unmapped_11", r, 8'h00);

        // pointer wrap 0xFF -> 0x00
        cs_begin(); xfer(8'hFF, r); xfer(8'hFF, r1); xfer(8'hFF, r2); xfer(8'hFF, r3); cs_end();
        check("wrap_b2", r2, 8'h00);
        check("wrap_b3", r3, 8'h41);

        // scratch register
        wr_reg(8'h20, 8'h5A);
        rd_reg(8'h20, r);
`ifdef ARGUS_SCRATCH_REG_EN
        check("scratch", r, 8'h5A);
`else
        check("scratch", r, 8'h00);
`endif
        leds("final_leds", 3'b100);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/argus_top.md
Name: argus_top

Overview:
- FPGA top level: SPI mode-0 slave bridged into a small byte-wide register file.
- Register file holds a read-only device ID string and an RGB LED control register.
- SPI pins are asynchronous to clk. They are synchronised and oversampled in the clk domain (12 MHz nominal).
- A transaction is one address byte followed by auto-incrementing data bytes.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on sclk/mosi/cs_n synchronisers (min 2)
- ID_VERSION, 8'h01, value returned at address 0x05

Ports:
- clk  input  1  system clock, 12 MHz nominal; sclk must be at most clk/8
- sys_rst  input  1  asynchronous, active-low reset
- sclk  input  1  SPI clock, idle low (mode 0)
- mosi  input  1  SPI data in, MSB first, sampled on sclk rising edge
- cs_n  input  1  SPI chip select, active low
- miso  output  1  SPI data out, MSB first, updated only on sclk falling edges
- led_r  output  1  red LED, active low
- led_g  output  1  green LED, active low
- led_b  output  1  blue LED, active low

Behaviour:
- Reset (sys_rst=0, asynchronous): LED_CTRL=0x00, led_r/g/b=1, miso=0, SPI state idle, all counters cleared.
- Synchronisers: sclk, mosi and cs_n each pass through SYNC_STAGES FFs. Rise and fall edges are detected in the clk domain.
- Framing: cs_n high aborts any byte in progress and returns to ADDR state with bit count 0; partial bytes are discarded. miso=0 while cs_n is high.
- States:
  - ADDR: first 8 rising edges shift in the address, MSB first. At the 8th rising edge, capture addr into ptr and go to DATA.
  - DATA: bytes k=1,2,… until cs_n goes high.
- Writes: data byte k received with value != 0xFF writes reg[addr+k-1] at its 8th rising edge. A data byte of 0xFF is a read/dummy byte and writes nothing. Writes to read-only or unmapped addresses are ignored.
- Reads, one-byte turnaround:
  - During the address byte and data byte 1, miso shifts 0x00.
  - Data byte k≥2 shifts reg[addr+k-2].
  - The outgoing byte is loaded, with its MSB driven, on the sclk falling edge that ends the previous byte.
  - Remaining bits shift on subsequent falling edges.
  - The read value is sampled at load time, so a write in the same transaction is visible to later bytes.
- Address arithmetic is 8-bit and wraps 0xFF→0x00. Unmapped reads return 0x00.
- Register map:
  - 0x00–0x04: RO ASCII "ARGUS" (0x41 0x52 0x47 0x55 0x53)
  - 0x05: RO ID_VERSION
  - 0x06: RO 0x00
  - 0x10: LED_CTRL RW; bit0=blue, bit1=green, bit2=red; bits[7:3] read back as written
  - 0x20: SCRATCH (optional feature only)
- LED outputs: led_b=~LED_CTRL[0], led_g=~LED_CTRL[1], led_r=~LED_CTRL[2]. Outputs update within 4 clk cycles of the write-completing sclk edge.
- Reset asserted mid-transaction: immediate abort. The next transaction requires a fresh cs_n falling edge.

Optional Feature:
- Macro ARGUS_SCRATCH_REG_EN.
- Defined: 8-bit RW scratch register at 0x20, reset 0x00, same write/read rules as LED_CTRL.
- Undefined: 0x20 is unmapped; reads return 0x00 and writes are ignored.

Test Plan:
- Reset release, cs_n low, send 0x00 then seven 0xFF -> responses to data bytes 1..7 are 0x00,'A','R','G','U','S',ID_VERSION; LEDs all 1.
- cs_n low, send 0x10 then 0x01, cs_n high -> led_b=0, led_g=1, led_r=1 within 4 clk.
- Then cs_n low, send 0x10, 0xFF, 0xFF -> response to data byte 2 is 0x01; LED state unchanged.
- Send 0x10, 0x06 -> led_g=0, led_r=0, led_b=1. Assert sys_rst -> LEDs all 1 and LED_CTRL reads 0x00.
- Deassert cs_n after 4 bits of a data byte 0x07 to 0x10 -> no write. Next transaction starts cleanly in ADDR state.
- Send 0xFF, 0xFF, 0xFF, 0xFF -> pointer wraps to 0x00; data byte 3 returns 'A'. With ARGUS_SCRATCH_REG_EN, write 0x5A to 0x20 then read it -> 0x5A; without the macro the read returns 0x00.
